// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
//  Shared definitions for the instruction-fetch stage:
//   - default reset PC and sequential PC increment
//   - fetch FSM state encoding
//   - helper that forces a byte address onto a 4-byte boundary
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_PC_STEP  = 32'd4;

    // IDLE : one-cycle bubble after reset before the first request
    // WAIT : request outstanding, response will be delivered to decode
    // KILL : request outstanding, but a redirect arrived; response is dropped
    // HOLD : fetched word buffered and presented to decode
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_KILL = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_t;

    // Instruction addresses are word aligned; redirect targets are trimmed.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_adder.sv
// -----------------------------------------------------------------------------
// fetch_unit_adder
//  Plain ripple-carry adder used for the sequential PC increment.
//  The result wraps modulo 2**WIDTH; there is no carry-out.
//  Ports:
//   a    in  WIDTH  first operand (current fetch address)
//   b    in  WIDTH  second operand (PC step)
//   sum  out WIDTH  a + b, truncated to WIDTH bits
// -----------------------------------------------------------------------------
module fetch_unit_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    // carry[i] is the carry into bit i; the final carry-out is not kept.
    logic [WIDTH-1:0] carry;

    assign carry[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign sum[gi] = a[gi] ^ b[gi] ^ carry[gi];
            if (gi < WIDTH - 1) begin : g_carry
                assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
            end
        end
    endgenerate

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//  Instruction-fetch stage. Keeps the program counter, issues one request at
//  a time to instruction memory (req/ack), and hands each fetched word to
//  decode (valid/ready). Redirects from downstream are accepted in any state.
//  Ports:
//   clk             in   1   clock, all state updates on posedge
//   rst             in   1   asynchronous active-high reset
//   imem_req        out  1   fetch request outstanding
//   imem_addr       out  32  fetch address, stable until acknowledged
//   imem_ack        in   1   memory returns imem_rdata this cycle
//   imem_rdata      in   32  instruction word, valid with imem_ack
//   redirect_valid  in   1   load a new PC this cycle
//   redirect_pc     in   32  redirect target (bits [1:0] ignored)
//   out_valid       out  1   out_instr/out_pc valid for decode
//   out_ready       in   1   decode accepts when out_valid & out_ready
//   out_instr       out  32  fetched instruction
//   out_pc          out  32  address of out_instr
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;                  // next address to fetch
    logic [31:0]  fetch_addr_reg, fetch_addr_next;  // address of outstanding request
    logic [31:0]  out_instr_reg, out_instr_next;
    logic [31:0]  out_pc_reg, out_pc_next;

    logic [31:0]  pc_plus_step;
    logic [31:0]  redirect_target;

    assign redirect_target = align_word(redirect_pc);

    fetch_unit_adder #(
        .WIDTH (32)
    ) u_adder (
        .a   (fetch_addr_reg),
        .b   (PC_STEP),
        .sum (pc_plus_step)
    );

    // Outputs come straight from registers, so every output is quiet
    // (0 / RESET_PC) the moment reset is asserted.
    assign imem_req  = (state_reg == ST_WAIT) || (state_reg == ST_KILL);
    assign imem_addr = fetch_addr_reg;
    assign out_valid = (state_reg == ST_HOLD);
    assign out_instr = out_instr_reg;
    assign out_pc    = out_pc_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            pc_reg         <= RESET_PC;
            fetch_addr_reg <= RESET_PC;
            out_instr_reg  <= 32'h0;
            out_pc_reg     <= 32'h0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            fetch_addr_reg <= fetch_addr_next;
            out_instr_reg  <= out_instr_next;
            out_pc_reg     <= out_pc_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        fetch_addr_next = fetch_addr_reg;
        out_instr_next  = out_instr_reg;
        out_pc_next     = out_pc_reg;

        case (state_reg)
            ST_IDLE: begin
                state_next = ST_WAIT;
                if (redirect_valid) begin
                    pc_next         = redirect_target;
                    fetch_addr_next = redirect_target;
                end
            end

            ST_WAIT: begin
                if (imem_ack) begin
                    if (redirect_valid) begin
                        // Response is stale: drop it and reissue at the
                        // target; req stays high so no extra idle cycle.
                        pc_next         = redirect_target;
                        fetch_addr_next = redirect_target;
                    end else begin
                        out_instr_next = imem_rdata;
                        out_pc_next    = fetch_addr_reg;
                        pc_next        = pc_plus_step;
                        state_next     = ST_HOLD;
                    end
                end else if (redirect_valid) begin
                    // The memory request cannot be withdrawn, so the address
                    // stays put and the eventual response is discarded.
                    pc_next    = redirect_target;
                    state_next = ST_KILL;
                end
            end

            ST_KILL: begin
                if (redirect_valid) begin
                    pc_next = redirect_target;
                end
                if (imem_ack) begin
                    // A redirect in the same cycle as the ack must win over
                    // the earlier stored target.
                    fetch_addr_next = redirect_valid ? redirect_target : pc_reg;
                    state_next      = ST_WAIT;
                end
            end

            ST_HOLD: begin
                if (redirect_valid) begin
                    // Buffered word is either taken this cycle (out_ready=1)
                    // or discarded; in both cases fetching restarts here.
                    pc_next         = redirect_target;
                    fetch_addr_next = redirect_target;
                    state_next      = ST_WAIT;
                end else if (out_ready) begin
                    fetch_addr_next = pc_reg;
                    state_next      = ST_WAIT;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] K = 32'hC0DE_0000;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    // Second instance with a reset PC at the top of the address space.
    logic        rst2;
    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic        imem_ack2;
    logic [31:0] imem_rdata2;
    logic        redirect_valid2;
    logic [31:0] redirect_pc2;
    logic        out_valid2;
    logic        out_ready2;
    logic [31:0] out_instr2;
    logic [31:0] out_pc2;

    int n_checks;
    int n_fail;

    fetch_unit u_dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    fetch_unit #(
        .RESET_PC (32'hFFFF_FFFC),
        .PC_STEP  (32'd4)
    ) u_dut_wrap (
        .clk            (clk),
        .rst            (rst2),
        .imem_req       (imem_req2),
        .imem_addr      (imem_addr2),
        .imem_ack       (imem_ack2),
        .imem_rdata     (imem_rdata2),
        .redirect_valid (redirect_valid2),
        .redirect_pc    (redirect_pc2),
        .out_valid      (out_valid2),
        .out_ready      (out_ready2),
        .out_instr      (out_instr2),
        .out_pc         (out_pc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ack, input logic [31:0] rdata, input logic rv,
                       input logic [31:0] rpc, input logic rdy,
                       input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                       input logic [31:0] e_instr, input logic [31:0] e_pc);
        vec_t v;
        v.ack = ack; v.rdata = rdata; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_instr = e_instr; v.e_pc = e_pc;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_main(input string tag, input logic e_req, input logic [31:0] e_addr,
                            input logic e_valid, input logic [31:0] e_instr,
                            input logic [31:0] e_pc);
        chk({tag, " imem_req"},  {31'b0, imem_req},  {31'b0, e_req});
        chk({tag, " imem_addr"}, imem_addr,          e_addr);
        chk({tag, " out_valid"}, {31'b0, out_valid}, {31'b0, e_valid});
        chk({tag, " out_instr"}, out_instr,          e_instr);
        chk({tag, " out_pc"},    out_pc,             e_pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; rst2 = 1'b1;
        imem_ack = 1'b0; imem_rdata = '0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        imem_ack2 = 1'b0; imem_rdata2 = '0; redirect_valid2 = 1'b0; redirect_pc2 = '0; out_ready2 = 1'b0;

        // ack,rdata,rv,rpc,rdy | req,addr,valid,instr,pc
        // 1-cycle memory, out_ready=1
        add(0, 0,      0, 0, 0,   0, 32'h0,   0, 32'h0,    32'h0);
        add(1, K|0,    0, 0, 0,   1, 32'h0,   0, 32'h0,    32'h0);
        add(0, 0,      0, 0, 1,   0, 32'h0,   1, K|0,      32'h0);
        add(1, K|4,    0, 0, 0,   1, 32'h4,   0, K|0,      32'h0);
        add(0, 0,      0, 0, 1,   0, 32'h4,   1, K|4,      32'h4);
        // ack delayed 3 cycles on address 8
        add(0, 0,      0, 0, 1,   1, 32'h8,   0, K|4,      32'h4);
        add(0, 0,      0, 0, 1,   1, 32'h8,   0, K|4,      32'h4);
        add(0, 0,      0, 0, 1,   1, 32'h8,   0, K|4,      32'h4);
        add(1, K|8,    0, 0, 1,   1, 32'h8,   0, K|4,      32'h4);
        // decode stalls 5 cycles; stray ack in HOLD ignored
        add(0, 0,      0, 0, 0,   0, 32'h8,   1, K|8,      32'h8);
        add(1, '1,     0, 0, 0,   0, 32'h8,   1, K|8,      32'h8);
        add(0, 0,      0, 0, 0,   0, 32'h8,   1, K|8,      32'h8);
        add(0, 0,      0, 0, 0,   0, 32'h8,   1, K|8,      32'h8);
        add(0, 0,      0, 0, 0,   0, 32'h8,   1, K|8,      32'h8);
        add(0, 0,      0, 0, 1,   0, 32'h8,   1, K|8,      32'h8);
        // redirect to 0x100 while waiting on 0xC
        add(0, 0,      1, 32'h100, 0, 1, 32'hC, 0, K|8,    32'h8);
        add(0, 0,      0, 0, 0,   1, 32'hC,   0, K|8,      32'h8);
        add(1, K|12,   0, 0, 0,   1, 32'hC,   0, K|8,      32'h8);
        add(1, K|32'h100, 0, 0, 0, 1, 32'h100, 0, K|8,     32'h8);
        // redirect to 0x200 in HOLD with out_ready=0
        add(0, 0,      1, 32'h200, 0, 0, 32'h100, 1, K|32'h100, 32'h100);
        add(1, K|32'h200, 0, 0, 0, 1, 32'h200, 0, K|32'h100, 32'h100);
        // redirect to 0x203 in HOLD with out_ready=1 -> fetch 0x200
        add(0, 0,      1, 32'h203, 1, 0, 32'h200, 1, K|32'h200, 32'h200);
        // ack and redirect together in WAIT: response dropped
        add(1, K|32'h200, 1, 32'h300, 0, 1, 32'h200, 0, K|32'h200, 32'h200);
        add(1, K|32'h300, 0, 0, 0, 1, 32'h300, 0, K|32'h200, 32'h200);
        add(0, 0,      0, 0, 1,   0, 32'h300, 1, K|32'h300, 32'h300);
        // redirect in WAIT, then a second redirect with the ack in KILL
        add(0, 0,      1, 32'h400, 0, 1, 32'h304, 0, K|32'h300, 32'h300);
        add(1, K|32'h304, 1, 32'h501, 0, 1, 32'h304, 0, K|32'h300, 32'h300);
        add(1, K|32'h500, 0, 0, 0, 1, 32'h500, 0, K|32'h300, 32'h300);
        add(0, 0,      0, 0, 1,   0, 32'h500, 1, K|32'h500, 32'h500);
        add(0, 0,      0, 0, 0,   1, 32'h504, 0, K|32'h500, 32'h500);

        repeat (2) @(negedge clk);
        #1;
        chk_main("reset", 0, 32'h0, 0, 32'h0, 32'h0);
        chk("reset wrap imem_addr", imem_addr2, 32'hFFFF_FFFC);
        chk("reset wrap imem_req", {31'b0, imem_req2}, 32'h0);
        @(negedge clk);
        rst = 1'b0; rst2 = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            imem_ack       = vecs[i].ack;
            imem_rdata     = vecs[i].rdata;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            out_ready      = vecs[i].rdy;
            #1;
            chk_main($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
                     vecs[i].e_valid, vecs[i].e_instr, vecs[i].e_pc);
            $display("vec%0d ack=%0b rv=%0b rdy=%0b -> req=%0b addr=%h valid=%0b pc=%h",
                     i, vecs[i].ack, vecs[i].rv, vecs[i].rdy, imem_req, imem_addr, out_valid, out_pc);
            @(negedge clk);
        end
        imem_ack = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;

        // Async reset mid-WAIT: outputs drop before any clock edge.
        #1;
        chk("pre-reset imem_req", {31'b0, imem_req}, 32'h1);
        #1;
        rst = 1'b1;
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        #1;
        chk_main("async reset", 0, 32'h0, 0, 32'h0, 32'h0);
        $display("async reset -> req=%0b addr=%h", imem_req, imem_addr);
        @(negedge clk);
        rst = 1'b0; imem_ack = 1'b0;
        // IDLE with redirect to 0x80
        redirect_valid = 1'b1; redirect_pc = 32'h82;
        #1;
        chk_main("idle", 0, 32'h0, 0, 32'h0, 32'h0);
        @(negedge clk);
        redirect_valid = 1'b0;
        imem_ack = 1'b1; imem_rdata = K | 32'h80;
        #1;
        chk_main("idle redirect", 1, 32'h80, 0, 32'h0, 32'h0);
        @(negedge clk);
        imem_ack = 1'b0; out_ready = 1'b1;
        #1;
        chk_main("fetch 0x80", 0, 32'h80, 1, K | 32'h80, 32'h80);
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk_main("fetch 0x84 req", 1, 32'h84, 0, K | 32'h80, 32'h80);
        $display("restart after reset -> addr=%h", imem_addr);

        // PC wrap on the second instance (held in WAIT at 0xFFFFFFFC).
        chk("wrap first req", {31'b0, imem_req2}, 32'h1);
        chk("wrap first addr", imem_addr2, 32'hFFFF_FFFC);
        imem_ack2 = 1'b1; imem_rdata2 = 32'h1234_5678;
        @(negedge clk);
        imem_ack2 = 1'b0; out_ready2 = 1'b1;
        #1;
        chk("wrap out_valid", {31'b0, out_valid2}, 32'h1);
        chk("wrap out_pc", out_pc2, 32'hFFFF_FFFC);
        chk("wrap out_instr", out_instr2, 32'h1234_5678);
        @(negedge clk);
        out_ready2 = 1'b0;
        #1;
        chk("wrap second req", {31'b0, imem_req2}, 32'h1);
        chk("wrap second addr", imem_addr2, 32'h0);
        imem_ack2 = 1'b1; imem_rdata2 = 32'h9ABC_DEF0;
        @(negedge clk);
        imem_ack2 = 1'b0;
        #1;
        chk("wrap second out_pc", out_pc2, 32'h0);
        chk("wrap second out_instr", out_instr2, 32'h9ABC_DEF0);
        $display("wrap instance -> second out_pc=%h", out_pc2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
